// File: rtl/mem_arb_if.sv
// mem_arb_if: signal bundle between the two-requester memory arbiter and its environment.
//   Requester A (core) / B (loader): req, we, addr, wdata, lock in; gnt, rvalid, rdata1/rdata2 out.
//   Memory port: mem_wr_en/mem_wr_addr/mem_wr_data and mem_rd_addr1/mem_rd_addr2 out,
//   mem_rd_data1/mem_rd_data2 in.
//   Status: done (sticky halt flag) out.
//   Modports: slave = arbiter view, master = requesters plus memory view.
interface mem_arb_if #(
    parameter int unsigned n = 8
);
    logic         a_req;
    logic         a_we;
    logic [n-1:0] a_addr;
    logic [n-1:0] a_wdata;
    logic         a_lock;
    logic         a_gnt;
    logic         a_rvalid;
    logic [n-1:0] a_rdata1;
    logic [n-1:0] a_rdata2;

    logic         b_req;
    logic         b_we;
    logic [n-1:0] b_addr;
    logic [n-1:0] b_wdata;
    logic         b_lock;
    logic         b_gnt;
    logic         b_rvalid;
    logic [n-1:0] b_rdata1;
    logic [n-1:0] b_rdata2;

    logic         mem_wr_en;
    logic [n-1:0] mem_wr_addr;
    logic [n-1:0] mem_wr_data;
    logic [n-1:0] mem_rd_addr1;
    logic [n-1:0] mem_rd_addr2;
    logic [n-1:0] mem_rd_data1;
    logic [n-1:0] mem_rd_data2;

    logic         done;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata, a_lock,
        input  b_req, b_we, b_addr, b_wdata, b_lock,
        input  mem_rd_data1, mem_rd_data2,
        output a_gnt, a_rvalid, a_rdata1, a_rdata2,
        output b_gnt, b_rvalid, b_rdata1, b_rdata2,
        output mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr1, mem_rd_addr2,
        output done
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata, a_lock,
        output b_req, b_we, b_addr, b_wdata, b_lock,
        output mem_rd_data1, mem_rd_data2,
        input  a_gnt, a_rvalid, a_rdata1, a_rdata2,
        input  b_gnt, b_rvalid, b_rdata1, b_rdata2,
        input  mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr1, mem_rd_addr2,
        input  done
    );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter giving requesters A and B single-cycle access to one
// memory with a write port and a dual read port, with lock support and a halt write.
//   clk   : single clock, rising edge
//   reset : asynchronous, active-low
//   bus   : mem_arb_if slave modport (requests, grants, read returns, memory port, done)
// Parameters: n = data/address width, LOCK_MAX = maximum consecutive locked grants.
module mem_arb #(
    parameter int unsigned n        = 8,
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic     clk,
    input  logic     reset,
    mem_arb_if.slave bus
);

    // lock_cnt counts re-grants made because of lock; a chain is lock_cnt+1 grants long
    localparam int unsigned CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(LOCK_MAX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             a_gnt_q, a_gnt_d;
    logic             b_gnt_q, b_gnt_d;
    logic             a_rvalid_q, a_rvalid_d;
    logic             b_rvalid_q, b_rvalid_d;
    logic [n-1:0]     a_rdata1_q, a_rdata1_d;
    logic [n-1:0]     a_rdata2_q, a_rdata2_d;
    logic [n-1:0]     b_rdata1_q, b_rdata1_d;
    logic [n-1:0]     b_rdata2_q, b_rdata2_d;
    logic             mem_wr_en_q, mem_wr_en_d;
    logic [n-1:0]     mem_wr_addr_q, mem_wr_addr_d;
    logic [n-1:0]     mem_wr_data_q, mem_wr_data_d;
    logic [n-1:0]     mem_rd_addr1_q, mem_rd_addr1_d;
    logic [n-1:0]     mem_rd_addr2_q, mem_rd_addr2_d;
    logic             done_q, done_d;
    logic             prio_a_q, prio_a_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

    logic             halt_c;
    logic             keep_a_c;
    logic             keep_b_c;
    logic             grant_a_c;
    logic             grant_b_c;
    logic             locked_c;
    logic             sel_we_c;
    logic [n-1:0]     sel_addr_c;
    logic [n-1:0]     sel_wdata_c;

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            a_gnt_q        <= 1'b0;
            b_gnt_q        <= 1'b0;
            a_rvalid_q     <= 1'b0;
            b_rvalid_q     <= 1'b0;
            a_rdata1_q     <= '0;
            a_rdata2_q     <= '0;
            b_rdata1_q     <= '0;
            b_rdata2_q     <= '0;
            mem_wr_en_q    <= 1'b0;
            mem_wr_addr_q  <= '0;
            mem_wr_data_q  <= '0;
            mem_rd_addr1_q <= '0;
            mem_rd_addr2_q <= '0;
            done_q         <= 1'b0;
            prio_a_q       <= 1'b1;
            lock_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            a_gnt_q        <= a_gnt_d;
            b_gnt_q        <= b_gnt_d;
            a_rvalid_q     <= a_rvalid_d;
            b_rvalid_q     <= b_rvalid_d;
            a_rdata1_q     <= a_rdata1_d;
            a_rdata2_q     <= a_rdata2_d;
            b_rdata1_q     <= b_rdata1_d;
            b_rdata2_q     <= b_rdata2_d;
            mem_wr_en_q    <= mem_wr_en_d;
            mem_wr_addr_q  <= mem_wr_addr_d;
            mem_wr_data_q  <= mem_wr_data_d;
            mem_rd_addr1_q <= mem_rd_addr1_d;
            mem_rd_addr2_q <= mem_rd_addr2_d;
            done_q         <= done_d;
            prio_a_q       <= prio_a_d;
            lock_cnt_q     <= lock_cnt_d;
        end
    end

    // Next-state: read return, halt detection, lock/round-robin arbitration
    always_comb begin
        state_d        = state_q;
        a_gnt_d        = 1'b0;
        b_gnt_d        = 1'b0;
        a_rvalid_d     = 1'b0;
        b_rvalid_d     = 1'b0;
        a_rdata1_d     = a_rdata1_q;
        a_rdata2_d     = a_rdata2_q;
        b_rdata1_d     = b_rdata1_q;
        b_rdata2_d     = b_rdata2_q;
        mem_wr_en_d    = 1'b0;
        mem_wr_addr_d  = mem_wr_addr_q;
        mem_wr_data_d  = mem_wr_data_q;
        mem_rd_addr1_d = mem_rd_addr1_q;
        mem_rd_addr2_d = mem_rd_addr2_q;
        done_d         = done_q;
        prio_a_d       = prio_a_q;
        lock_cnt_d     = lock_cnt_q;
        grant_a_c      = 1'b0;
        grant_b_c      = 1'b0;
        locked_c       = 1'b0;

        // The write issued in the current grant cycle is the halt command
        halt_c = ((state_q == GNT_A) || (state_q == GNT_B)) && mem_wr_en_q &&
                 (mem_wr_addr_q == '1) && (mem_wr_data_q == n'(1));

        // Lock is honoured until the chain reaches LOCK_MAX, then only if the other side is idle
        keep_a_c = (state_q == GNT_A) && bus.a_req && bus.a_lock &&
                   ((lock_cnt_q < CNT_CAP) || !bus.b_req);
        keep_b_c = (state_q == GNT_B) && bus.b_req && bus.b_lock &&
                   ((lock_cnt_q < CNT_CAP) || !bus.a_req);

        // A read granted in the ending cycle returns its memory data now
        if ((state_q == GNT_A) && !mem_wr_en_q) begin
            a_rvalid_d = 1'b1;
            a_rdata1_d = bus.mem_rd_data1;
            a_rdata2_d = bus.mem_rd_data2;
        end
        if ((state_q == GNT_B) && !mem_wr_en_q) begin
            b_rvalid_d = 1'b1;
            b_rdata1_d = bus.mem_rd_data1;
            b_rdata2_d = bus.mem_rd_data2;
        end

        if (keep_a_c) begin
            grant_a_c = 1'b1;
            locked_c  = 1'b1;
        end else if (keep_b_c) begin
            grant_b_c = 1'b1;
            locked_c  = 1'b1;
        end else if (bus.a_req && bus.b_req) begin
            grant_a_c = prio_a_q;
            grant_b_c = !prio_a_q;
        end else begin
            grant_a_c = bus.a_req;
            grant_b_c = bus.b_req;
        end

        sel_we_c    = grant_b_c ? bus.b_we    : bus.a_we;
        sel_addr_c  = grant_b_c ? bus.b_addr  : bus.a_addr;
        sel_wdata_c = grant_b_c ? bus.b_wdata : bus.a_wdata;

        if (state_q == DONE) begin
            lock_cnt_d = '0;
        end else if (halt_c) begin
            state_d    = DONE;
            done_d     = 1'b1;
            lock_cnt_d = '0;
        end else if (grant_a_c || grant_b_c) begin
            state_d     = grant_b_c ? GNT_B : GNT_A;
            a_gnt_d     = grant_a_c;
            b_gnt_d     = grant_b_c;
            prio_a_d    = grant_b_c;
            mem_wr_en_d = sel_we_c;
            if (sel_we_c) begin
                mem_wr_addr_d = sel_addr_c;
                mem_wr_data_d = sel_wdata_c;
            end else begin
                mem_rd_addr1_d = sel_addr_c;
                mem_rd_addr2_d = sel_addr_c + n'(1);
            end
            if (!locked_c) begin
                lock_cnt_d = '0;
            end else if (lock_cnt_q < CNT_CAP) begin
                lock_cnt_d = lock_cnt_q + CNT_W'(1);
            end
        end else begin
            state_d    = IDLE;
            lock_cnt_d = '0;
        end
    end

    assign bus.a_gnt        = a_gnt_q;
    assign bus.b_gnt        = b_gnt_q;
    assign bus.a_rvalid     = a_rvalid_q;
    assign bus.b_rvalid     = b_rvalid_q;
    assign bus.a_rdata1     = a_rdata1_q;
    assign bus.a_rdata2     = a_rdata2_q;
    assign bus.b_rdata1     = b_rdata1_q;
    assign bus.b_rdata2     = b_rdata2_q;
    assign bus.mem_wr_en    = mem_wr_en_q;
    assign bus.mem_wr_addr  = mem_wr_addr_q;
    assign bus.mem_wr_data  = mem_wr_data_q;
    assign bus.mem_rd_addr1 = mem_rd_addr1_q;
    assign bus.mem_rd_addr2 = mem_rd_addr2_q;
    assign bus.done         = done_q;

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter n, default 8, giving the data and address width in bits.
REQ-002 SHALL have parameter LOCK_MAX, default 4, giving the maximum number of consecutive locked grants.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 a_req / b_req  input  1  transaction request from requester A (core) / B (loader).
REQ-006 a_we / b_we  input  1  1 = write, 0 = read.
REQ-007 a_addr / b_addr  input  n  transaction address.
REQ-008 a_wdata / b_wdata  input  n  write data.
REQ-009 a_lock / b_lock  input  1  asks to keep the grant for the next cycle.
REQ-010 a_gnt / b_gnt  output  1  grant, high for exactly one cycle per accepted transaction.
REQ-011 a_rvalid / b_rvalid  output  1  read data valid, one cycle.
REQ-012 a_rdata1, a_rdata2 / b_rdata1, b_rdata2  output  n  read data: mem[addr] and mem[addr+1].
REQ-013 mem_wr_data, mem_wr_addr  output  n  memory write port.
REQ-014 mem_wr_en  output  1  memory write enable.
REQ-015 mem_rd_addr1, mem_rd_addr2  output  n  memory read addresses.
REQ-016 mem_rd_data1, mem_rd_data2  input  n  memory read data.
REQ-017 done  output  1  sticky halt flag.

Function
REQ-018 SHALL use the FSM states IDLE, GNT_A, GNT_B and DONE. All mem_* and gnt outputs SHALL be registered.
REQ-019 Acceptance: when a request is sampled high at edge k, the grant SHALL be high from edge k until edge k+1. Requesters hold their request fields until they see the grant. A request still high at the edge that ends the grant is a new request.
REQ-020 Write grant: drive mem_wr_en=1, mem_wr_addr=addr and mem_wr_data=wdata during the grant cycle. Memory commits on the falling edge inside that cycle.
REQ-021 Read grant: drive mem_rd_addr1=addr, mem_rd_addr2=addr+1 (mod 2^n, so 0xff wraps to 0x00) and mem_wr_en=0.
REQ-022 Read return: capture mem_rd_data1/2 at edge k+1 into the granted requester's rdata1/rdata2 and assert its rvalid from edge k+1 to k+2. The other requester's rdata SHALL hold.
REQ-023 Single grant: at most one of a_gnt/b_gnt SHALL be high in any cycle. mem_wr_en SHALL be 0 whenever neither grant is high.
REQ-024 Arbitration is round-robin. When both requesters are pending, grant the one not granted most recently. After reset A has priority.
REQ-025 Lock: if the granted requester has lock=1 and req=1 at the end of its grant, it SHALL be granted again back-to-back.
REQ-026 A lock_cnt SHALL count consecutive locked grants. After LOCK_MAX consecutive grants the lock SHALL be ignored for one arbitration if the other requester is pending. lock_cnt SHALL clear on any switch or idle cycle.
REQ-027 Lone requester: a requester alone SHALL be granted every cycle it requests, lock or not.
REQ-028 Halt: a granted write with addr=all-ones and wdata=1 (0xff/0x01 at n=8) SHALL perform the write, then enter DONE with done=1 from the next edge.
REQ-029 In DONE: no further grants; the state is left only by reset.
REQ-030 Reads to the all-ones address SHALL NOT set done.

Reset
REQ-031 On reset=0, immediately and asynchronously: all gnt, rvalid, mem_wr_en and done go to 0; all rdata, mem addresses and mem_wr_data go to 0; state goes to IDLE; priority goes to A; lock_cnt goes to 0.
REQ-032 Reset mid-grant SHALL abort the transaction with no rvalid issued. A write whose falling edge has not yet occurred SHALL NOT commit.
REQ-033 The first grant after reset release SHALL occur no earlier than the first rising edge with reset=1.

Verification
REQ-034 Single write: A writes 0x10 to 0x20 -> a_gnt high 1 cycle, mem_wr_en=1, addr 0x20, data 0x10.
REQ-035 Read back: B reads 0x20 after that write -> b_rvalid the cycle after b_gnt; b_rdata1=0x10, b_rdata2=mem[0x21].
REQ-036 Contention: A and B requesting continuously with no lock -> grants alternate A,B,A,B starting with A.
REQ-037 Lock cap: A holds lock with B pending -> A granted 4 consecutive cycles, then B once, then A again.
REQ-038 Wrap and halt: read of 0xff -> rd_addr2=0x00 and done stays 0. A then writes 0x01 to 0xff -> write performed, done=1 next cycle, no further grants.
REQ-039 Reset mid-read: assert reset during the b_gnt cycle -> outputs zero at once, no b_rvalid, A has priority afterwards.
